// File: rtl/lfsr_pkt_decrypt_if.sv
// rtl/lfsr_pkt_decrypt_if.sv - config, input stream and output stream bundle for the LFSR packet decryptor
interface lfsr_pkt_decrypt_if #(
    parameter int LW = 5
);
    logic          cfg_load;
    logic [LW-1:0] cfg_taps;
    logic [LW-1:0] cfg_seed;
    logic [3:0]    cfg_pre_len;
    logic [7:0]    in_byte;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    out_byte;
    logic          out_valid;
    logic          out_ready;
    logic          pkt_done;
    logic          pre_err;
    logic          busy;

    modport master (
        output cfg_load, cfg_taps, cfg_seed, cfg_pre_len, in_byte, in_valid, out_ready,
        input  in_ready, out_byte, out_valid, pkt_done, pre_err, busy
    );

    modport slave (
        input  cfg_load, cfg_taps, cfg_seed, cfg_pre_len, in_byte, in_valid, out_ready,
        output in_ready, out_byte, out_valid, pkt_done, pre_err, busy
    );
endinterface

// File: rtl/lfsr_pkt_decrypt.sv
// rtl/lfsr_pkt_decrypt.sv - LFSR keystream packet decryptor with preamble check and one-entry output register
module lfsr_step #(
    parameter int LW = 5
) (
    input  logic [LW-1:0] state,
    input  logic [LW-1:0] taps,
    output logic [LW-1:0] next
);
    assign next = {state[LW-2:0], ^(state & taps)};
endmodule

module lfsr_pkt_decrypt #(
    parameter int         PKT_LEN  = 32,
    parameter logic [7:0] PRE_CHAR = 8'h5F,
    parameter int         LW       = 5
) (
    input logic               clk,
    input logic               rst_n,
    lfsr_pkt_decrypt_if.slave bus
);
    localparam int CW = $clog2(PKT_LEN + 1);

    typedef enum logic [1:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        DRAIN
    } state_t;

    state_t        state;
    logic [LW-1:0] lfsr;
    logic [LW-1:0] lfsr_next;
    logic [LW-1:0] taps_q;
    logic [3:0]    pre_len_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [7:0]    dec;
    logic [7:0]    out_byte_q;
    logic          out_valid_q;
    logic          pkt_done_q;
    logic          pre_err_q;
    logic          rdy;
    logic          accept;
    logic          consume;
    logic          last_byte;
    logic          last_pre;

    lfsr_step #(.LW(LW)) u_step (
        .state (lfsr),
        .taps  (taps_q),
        .next  (lfsr_next)
    );

    // Only the low LW bits carry keystream; bit 7 is the marker and is never forwarded.
    assign dec       = {1'b0, bus.in_byte[6:LW], bus.in_byte[LW-1:0] ^ lfsr};
    assign cnt_inc   = cnt + 1'b1;
    assign last_byte = (cnt_inc == CW'(PKT_LEN));
    assign last_pre  = (cnt_inc == CW'(pre_len_q));
    assign accept    = bus.in_valid && rdy;
    assign consume   = out_valid_q && bus.out_ready;

    always_comb begin
        rdy = 1'b0;
        case (state)
            PREAMBLE: rdy = 1'b1;
            PAYLOAD:  rdy = !out_valid_q || bus.out_ready;
            default:  rdy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lfsr        <= '0;
            taps_q      <= '0;
            pre_len_q   <= '0;
            cnt         <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
            pkt_done_q  <= 1'b0;
            pre_err_q   <= 1'b0;
        end else begin
            pkt_done_q <= 1'b0;
            // A load in the same cycle below overrides this clear.
            if (consume) begin
                out_valid_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (bus.cfg_load) begin
                        taps_q    <= bus.cfg_taps;
                        pre_len_q <= bus.cfg_pre_len;
                        lfsr      <= bus.cfg_seed;
                        cnt       <= '0;
                        pre_err_q <= 1'b0;
                        state     <= (bus.cfg_pre_len != 4'd0) ? PREAMBLE : PAYLOAD;
                    end
                end
                PREAMBLE: begin
                    if (accept) begin
                        cnt  <= cnt_inc;
                        lfsr <= lfsr_next;
                        if (bus.in_byte[7] || dec != PRE_CHAR) begin
                            pre_err_q <= 1'b1;
                        end
                        // Packet length wins so an oversize preamble ends the packet.
                        if (last_byte) begin
                            state <= DRAIN;
                        end else if (last_pre) begin
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        cnt         <= cnt_inc;
                        lfsr        <= lfsr_next;
                        out_byte_q  <= dec;
                        out_valid_q <= 1'b1;
                        if (!bus.in_byte[7]) begin
                            pre_err_q <= 1'b1;
                        end
                        if (last_byte) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!out_valid_q || bus.out_ready) begin
                        pkt_done_q <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_byte  = out_byte_q;
    assign bus.out_valid = out_valid_q;
    assign bus.pkt_done  = pkt_done_q;
    assign bus.pre_err   = pre_err_q;
    assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_lfsr_pkt_decrypt.sv
// tb/tb_lfsr_pkt_decrypt.sv - randomized self-checking bench for lfsr_pkt_decrypt
module tb_lfsr_pkt_decrypt;
    localparam int PKT_LEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lfsr_pkt_decrypt_if #(.LW(5)) bus ();

    lfsr_pkt_decrypt #(.PKT_LEN(PKT_LEN), .PRE_CHAR(8'h5F), .LW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] in_stream [PKT_LEN];
    logic [7:0] exp_out [$];
    logic [7:0] got_out [$];
    bit         exp_err;
    int         done_cnt;
    bit         timeout;
    bit         err_final, err_dropped, err_at_start, busy_at_start, busy_after;
    int         first_pay_acc_cyc, first_valid_cyc;
    int         stall_samples, stall_ready_hi, stall_byte_bad, resume_gaps;
    logic [7:0] stall_byte;

    function automatic int key_step(int s, int t);
        return ((s * 2) % 32) + ($countones(s & t) % 2);
    endfunction

    task automatic build_stream(input int taps, input int seed, input int pre_len);
        int k, plain, mark;
        k = seed;
        for (int i = 0; i < PKT_LEN; i++) begin
            if (i < pre_len) begin
                plain = 'h5F;
                mark  = 0;
            end else begin
                plain = int'($urandom_range(0, 127));
                mark  = 1;
            end
            in_stream[i] = 8'(mark * 128 + (plain & 'h60) + ((plain & 'h1F) ^ k));
            k = key_step(k, taps);
        end
    endtask

    task automatic model_expect(input int taps, input int seed, input int pre_len);
        int k, b, d, eff;
        k = seed;
        eff = (pre_len > PKT_LEN) ? PKT_LEN : pre_len;
        exp_out.delete();
        exp_err = 1'b0;
        for (int i = 0; i < PKT_LEN; i++) begin
            b = int'(in_stream[i]);
            d = (b & 'h60) + ((b & 'h1F) ^ k);
            if (i < eff) begin
                if (b >= 128 || d != 'h5F) exp_err = 1'b1;
            end else begin
                exp_out.push_back(8'(d));
                if (b < 128) exp_err = 1'b1;
            end
            k = key_step(k, taps);
        end
    endtask

    function automatic int count_bad();
        int bad;
        bad = 0;
        for (int i = 0; i < exp_out.size() && i < got_out.size(); i++)
            if (got_out[i] !== exp_out[i]) bad++;
        if (got_out.size() != exp_out.size()) bad++;
        return bad;
    endfunction

    // mode 0: full rate, 1: stall output for 8 cycles at first valid, 2: random valid/ready
    task automatic run_packet(input int taps, input int seed, input int pre_len, input int mode,
                              input bit noisy, input int stop_after, input int post);
        int idx, cyc, hold;
        bit stall_started, released, err_seen;
        idx = 0; cyc = 0; hold = 0;
        stall_started = 0; released = 0; err_seen = 0;
        got_out.delete();
        done_cnt = 0; timeout = 0; err_dropped = 0;
        first_pay_acc_cyc = -1; first_valid_cyc = -1;
        stall_samples = 0; stall_ready_hi = 0; stall_byte_bad = 0; resume_gaps = 0;
        bus.cfg_taps = 5'(taps);
        bus.cfg_seed = 5'(seed);
        bus.cfg_pre_len = 4'(pre_len);
        bus.cfg_load = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.cfg_load = 1'b0;
        bus.cfg_taps = 5'($urandom);
        bus.cfg_seed = 5'($urandom);
        bus.cfg_pre_len = 4'($urandom);
        busy_at_start = bus.busy;
        err_at_start = bus.pre_err;
        forever begin
            if (noisy && bus.busy) begin
                bus.cfg_load = 1'($urandom);
                bus.cfg_taps = 5'($urandom);
                bus.cfg_seed = 5'($urandom);
                bus.cfg_pre_len = 4'($urandom);
            end else begin
                bus.cfg_load = 1'b0;
            end
            bus.in_valid = (idx < PKT_LEN) && (mode != 2 || $urandom_range(0, 3) != 0);
            bus.in_byte = (idx < PKT_LEN) ? in_stream[idx] : 8'($urandom);
            if (mode == 1) begin
                if (!stall_started && bus.out_valid) begin
                    stall_started = 1;
                    hold = 8;
                    stall_byte = bus.out_byte;
                end
                bus.out_ready = (hold == 0);
            end else if (mode == 2) begin
                bus.out_ready = ($urandom_range(0, 2) != 0);
            end else begin
                bus.out_ready = 1'b1;
            end
            #1;
            if (hold > 0) begin
                stall_samples++;
                if (bus.in_ready) stall_ready_hi++;
                if (!bus.out_valid || bus.out_byte !== stall_byte) stall_byte_bad++;
                hold--;
                if (hold == 0) released = 1;
            end else if (released && got_out.size() < exp_out.size() && !(bus.out_valid && bus.out_ready)) begin
                resume_gaps++;
            end
            if (first_valid_cyc < 0 && bus.out_valid) first_valid_cyc = cyc;
            if (bus.in_valid && bus.in_ready) begin
                if (idx == pre_len && first_pay_acc_cyc < 0) first_pay_acc_cyc = cyc;
                idx++;
            end
            if (bus.out_valid && bus.out_ready) got_out.push_back(bus.out_byte);
            if (err_seen && !bus.pre_err) err_dropped = 1;
            err_seen |= bus.pre_err;
            err_final = bus.pre_err;
            if (bus.pkt_done) done_cnt++;
            if (bus.pkt_done || (stop_after > 0 && idx >= stop_after)) break;
            if (cyc >= 3000) begin
                timeout = 1;
                break;
            end
            cyc++;
            @(negedge clk);
        end
        bus.cfg_load = 1'b0;
        if (stop_after > 0) begin
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < post; i++) begin
            @(negedge clk);
            #1;
            if (bus.pkt_done) done_cnt++;
        end
        busy_after = bus.busy;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.pkt_done, bus.pre_err, bus.busy} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {bus.in_ready, bus.out_valid, bus.pkt_done, bus.pre_err, bus.busy});
        else n_pass++;
        n_checks++;
        if (bus.out_byte !== 8'h00) $display("FAIL reset_out_byte: got %h want 00", bus.out_byte);
        else n_pass++;
    endtask

    task automatic test_nominal();
        build_stream('h12, 'h01, 2);
        in_stream[2] = 8'hC4;
        model_expect('h12, 'h01, 2);
        @(negedge clk);
        run_packet('h12, 'h01, 2, 0, 0, 0, 4);
        n_checks++;
        if (timeout !== 1'b0) $display("FAIL nominal_timeout: got %0d want 0", timeout);
        else n_pass++;
        n_checks++;
        if (got_out.size() !== 30) $display("FAIL nominal_count: got %0d want 30", got_out.size());
        else n_pass++;
        n_checks++;
        if (got_out.size() == 0 || got_out[0] !== 8'h41) $display("FAIL nominal_first_byte: got %h want 41", (got_out.size() > 0) ? got_out[0] : 8'hxx);
        else n_pass++;
        n_checks++;
        if (count_bad() !== 0) $display("FAIL nominal_payload: got %0d bad bytes want 0", count_bad());
        else n_pass++;
        n_checks++;
        if (first_valid_cyc !== first_pay_acc_cyc + 1) $display("FAIL nominal_latency: got cycle %0d want %0d", first_valid_cyc, first_pay_acc_cyc + 1);
        else n_pass++;
        n_checks++;
        if (err_final !== 1'b0) $display("FAIL nominal_pre_err: got %0d want 0", err_final);
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1) $display("FAIL nominal_done_pulses: got %0d want 1", done_cnt);
        else n_pass++;
        n_checks++;
        if (busy_after !== 1'b0) $display("FAIL nominal_busy_after: got %0d want 0", busy_after);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        build_stream('h12, 'h01, 2);
        in_stream[2] = 8'hC4;
        model_expect('h12, 'h01, 2);
        @(negedge clk);
        run_packet('h12, 'h01, 2, 1, 0, 0, 3);
        n_checks++;
        if (stall_samples !== 8) $display("FAIL bp_stall_samples: got %0d want 8", stall_samples);
        else n_pass++;
        n_checks++;
        if (stall_ready_hi !== 0) $display("FAIL bp_in_ready_during_stall: got %0d want 0", stall_ready_hi);
        else n_pass++;
        n_checks++;
        if (stall_byte_bad !== 0 || stall_byte !== 8'h41) $display("FAIL bp_hold: got %0d bad, byte %h want 0 bad, byte 41", stall_byte_bad, stall_byte);
        else n_pass++;
        n_checks++;
        if (count_bad() !== 0) $display("FAIL bp_payload: got %0d bad bytes want 0 (count %0d)", count_bad(), got_out.size());
        else n_pass++;
        n_checks++;
        if (resume_gaps !== 0) $display("FAIL bp_resume_rate: got %0d gaps want 0", resume_gaps);
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1 || timeout) $display("FAIL bp_done: got %0d (timeout %0d) want 1", done_cnt, timeout);
        else n_pass++;
    endtask

    task automatic test_preamble_err();
        build_stream('h12, 'h01, 2);
        in_stream[0] = 8'h5F;
        model_expect('h12, 'h01, 2);
        @(negedge clk);
        run_packet('h12, 'h01, 2, 0, 0, 0, 2);
        n_checks++;
        if (err_final !== 1'b1 || err_dropped !== 1'b0) $display("FAIL pre_err_sticky: got final %0d dropped %0d want 1 0", err_final, err_dropped);
        else n_pass++;
        n_checks++;
        if (count_bad() !== 0 || done_cnt !== 1) $display("FAIL pre_err_payload: got %0d bad, %0d done want 0 bad, 1 done", count_bad(), done_cnt);
        else n_pass++;
        build_stream('h12, 'h01, 2);
        model_expect('h12, 'h01, 2);
        @(negedge clk);
        run_packet('h12, 'h01, 2, 0, 0, 0, 2);
        n_checks++;
        if (err_at_start !== 1'b0 || err_final !== 1'b0) $display("FAIL pre_err_cleared: got start %0d final %0d want 0 0", err_at_start, err_final);
        else n_pass++;
    endtask

    task automatic test_marker_err();
        int taps, seed, pos;
        taps = int'($urandom_range(1, 31));
        seed = int'($urandom_range(1, 31));
        pos  = int'($urandom_range(3, PKT_LEN - 1));
        build_stream(taps, seed, 3);
        in_stream[pos] = in_stream[pos] & 8'h7F;
        model_expect(taps, seed, 3);
        @(negedge clk);
        run_packet(taps, seed, 3, 2, 0, 0, 2);
        n_checks++;
        if (err_final !== exp_err || exp_err !== 1'b1) $display("FAIL marker_err: got %0d want 1", err_final);
        else n_pass++;
        n_checks++;
        if (count_bad() !== 0 || got_out.size() !== 29) $display("FAIL marker_payload: got %0d bad, count %0d want 0 bad, count 29", count_bad(), got_out.size());
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1 || timeout) $display("FAIL marker_done: got %0d want 1", done_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int taps, seed;
        build_stream('h12, 'h01, 2);
        in_stream[0] = 8'h5F;
        model_expect('h12, 'h01, 2);
        @(negedge clk);
        run_packet('h12, 'h01, 2, 0, 0, 10, 0);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.pre_err !== 1'b1 || bus.busy !== 1'b1) $display("FAIL midpkt_state: got valid %0d err %0d busy %0d want 1 1 1", bus.out_valid, bus.pre_err, bus.busy);
        else n_pass++;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.out_valid, bus.pkt_done, bus.pre_err, bus.busy} !== 5'b0 || bus.out_byte !== 8'h00)
            $display("FAIL async_reset: got flags %b byte %h want 00000 00", {bus.in_ready, bus.out_valid, bus.pkt_done, bus.pre_err, bus.busy}, bus.out_byte);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        taps = int'($urandom_range(1, 31));
        seed = int'($urandom_range(1, 31));
        build_stream(taps, seed, 5);
        model_expect(taps, seed, 5);
        run_packet(taps, seed, 5, 0, 0, 0, 2);
        n_checks++;
        if (count_bad() !== 0 || err_final !== 1'b0 || done_cnt !== 1) $display("FAIL post_reset_packet: got %0d bad err %0d done %0d want 0 0 1", count_bad(), err_final, done_cnt);
        else n_pass++;
    endtask

    task automatic test_edges();
        int taps, seed;
        taps = int'($urandom_range(1, 31));
        seed = int'($urandom_range(1, 31));
        build_stream(taps, seed, 0);
        model_expect(taps, seed, 0);
        @(negedge clk);
        run_packet(taps, seed, 0, 2, 0, 0, 2);
        n_checks++;
        if (count_bad() !== 0 || got_out.size() !== 32) $display("FAIL pre_len0: got %0d bad count %0d want 0 bad count 32", count_bad(), got_out.size());
        else n_pass++;

        taps = int'($urandom_range(1, 31));
        build_stream(taps, 0, 4);
        @(negedge clk);
        run_packet(taps, 0, 4, 0, 0, 0, 2);
        begin
            int bad;
            bad = (got_out.size() == 28) ? 0 : 1;
            for (int i = 0; i < got_out.size() && i < 28; i++)
                if (got_out[i] !== (in_stream[4 + i] & 8'h7F)) bad++;
            n_checks++;
            if (bad !== 0) $display("FAIL seed0_passthru: got %0d bad want 0", bad);
            else n_pass++;
        end

        taps = int'($urandom_range(1, 31));
        seed = int'($urandom_range(1, 31));
        build_stream(taps, seed, 15);
        model_expect(taps, seed, 15);
        @(negedge clk);
        run_packet(taps, seed, 15, 0, 1, 0, 4);
        n_checks++;
        if (count_bad() !== 0 || got_out.size() !== 17) $display("FAIL pre_len15_noisy_cfg: got %0d bad count %0d want 0 bad count 17", count_bad(), got_out.size());
        else n_pass++;
        n_checks++;
        if (done_cnt !== 1 || err_final !== 1'b0) $display("FAIL pre_len15_done: got done %0d err %0d want 1 0", done_cnt, err_final);
        else n_pass++;

        for (int p = 0; p < 4; p++) begin
            int pl;
            taps = int'($urandom_range(0, 31));
            seed = int'($urandom_range(0, 31));
            pl   = int'($urandom_range(0, 15));
            build_stream(taps, seed, pl);
            if ($urandom_range(0, 1) == 1) in_stream[$urandom_range(0, PKT_LEN - 1)] ^= 8'h80;
            model_expect(taps, seed, pl);
            @(negedge clk);
            run_packet(taps, seed, pl, 2, 1, 0, 2);
            n_checks++;
            if (count_bad() !== 0 || err_final !== exp_err || done_cnt !== 1 || timeout)
                $display("FAIL random_pkt%0d: got %0d bad err %0d done %0d want 0 bad err %0d done 1", p, count_bad(), err_final, done_cnt, exp_err);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int taps, seed;
        taps = int'($urandom_range(1, 31));
        seed = int'($urandom_range(1, 31));
        build_stream(taps, seed, 3);
        model_expect(taps, seed, 3);
        @(negedge clk);
        run_packet(taps, seed, 3, 0, 0, 0, 0);
        n_checks++;
        if (count_bad() !== 0 || done_cnt !== 1) $display("FAIL b2b_first: got %0d bad done %0d want 0 1", count_bad(), done_cnt);
        else n_pass++;
        taps = int'($urandom_range(1, 31));
        seed = int'($urandom_range(1, 31));
        build_stream(taps, seed, 1);
        model_expect(taps, seed, 1);
        run_packet(taps, seed, 1, 0, 0, 0, 2);
        n_checks++;
        if (busy_at_start !== 1'b1) $display("FAIL b2b_load_accepted: got busy %0d want 1", busy_at_start);
        else n_pass++;
        n_checks++;
        if (count_bad() !== 0 || got_out.size() !== 31 || done_cnt !== 1) $display("FAIL b2b_second: got %0d bad count %0d done %0d want 0 31 1", count_bad(), got_out.size(), done_cnt);
        else n_pass++;
    endtask

    initial begin
        bus.cfg_load = 1'b0;
        bus.cfg_taps = '0;
        bus.cfg_seed = '0;
        bus.cfg_pre_len = '0;
        bus.in_byte = '0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_nominal();
        test_backpressure();
        test_preamble_err();
        test_marker_err();
        test_reset_mid();
        test_edges();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
